foc_loop_sched: RTL

Periodic sequencer and PID-config arbiter for the FOC pipeline (`top`). Generates the loop trigger (`valid`) at a programmed period and tracks the pipeline's `ready` handshake. Counts overruns, measures loop latency and times out a hung loop. Grants host writes to the `pid_d` and `pid_q` gain registers only while the pipeline is idle, so gains never change mid-iteration.

---
 rtl/foc_pkg.sv | 14 +
 rtl/tick_gen.sv | 31 +++
 rtl/foc_loop_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/foc_pkg.sv
// Shared types and constants for the FOC loop scheduler.
package foc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } sched_state_t;

  localparam logic CFG_SEL_D = 1'b0;
  localparam logic CFG_SEL_Q = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Free-running period counter; emits a one-cycle tick every `period` cycles.
module tick_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             run;

  assign run = enable && (period != '0);
  // Live compare: lowering period below cnt fires on the next cycle.
  assign tick = run && (cnt >= period - ONE);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/foc_loop_sched.sv
// Periodic launcher for the FOC pipeline with overrun/latency/timeout tracking
// and an idle-only arbiter for PID gain writes.
module foc_loop_sched
  import foc_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [CNT_W-1:0]   period,
  input  logic               foc_ready,
  output logic               foc_valid,
  input  logic               cfg_req,
  input  logic               cfg_sel,
  input  logic [D_WIDTH-1:0] cfg_addr,
  input  logic [D_WIDTH-1:0] cfg_data,
  output logic               cfg_ack,
  output logic               pid_d_wen,
  output logic               pid_q_wen,
  output logic [D_WIDTH-1:0] pid_addr,
  output logic [D_WIDTH-1:0] pid_data,
  output logic               busy,
  output logic               fault,
  output logic [CNT_W-1:0]   overrun_cnt,
  output logic [CNT_W-1:0]   last_latency
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int SAT_W = TO_W + CNT_W;
  localparam logic [TO_W-1:0]  LAT_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]  LAT_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    return v + CNT_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_lat(input logic [TO_W-1:0] v);
    logic [SAT_W-1:0] wide;
    wide = SAT_W'(v);
    if (wide > SAT_W'(CNT_MAX)) return CNT_MAX;
    return wide[CNT_W-1:0];
  endfunction

  sched_state_t    state_q;
  logic            pend_q;
  logic [TO_W-1:0] lat_q;
  logic            tick;
  logic            launch;
  logic            drop;
  logic            pend_set;
  logic            run_done;

  tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  assign busy  = (state_q == RUN);
  assign fault = (state_q == FAULT);

  // foc_valid is high only in the first RUN cycle, which masks ready there.
  assign run_done = (state_q == RUN) && !foc_valid && foc_ready;

  always_comb begin
    launch   = 1'b0;
    drop     = 1'b0;
    pend_set = 1'b0;
    case (state_q)
      IDLE: begin
        launch = enable && (pend_q || (tick && foc_ready));
        drop   = tick && (pend_q || !foc_ready);
      end
      WR: begin
        pend_set = tick && !pend_q;
        drop     = tick && pend_q;
      end
      default: drop = tick;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      lat_q        <= '0;
      foc_valid    <= 1'b0;
      cfg_ack      <= 1'b0;
      pid_d_wen    <= 1'b0;
      pid_q_wen    <= 1'b0;
      pid_addr     <= '0;
      pid_data     <= '0;
      overrun_cnt  <= '0;
      last_latency <= '0;
    end else begin
      foc_valid <= 1'b0;
      cfg_ack   <= 1'b0;
      pid_d_wen <= 1'b0;
      pid_q_wen <= 1'b0;

      if (drop) overrun_cnt <= sat_inc(overrun_cnt);

      if (!enable || launch) pend_q <= 1'b0;
      else if (pend_set)     pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q   <= RUN;
            foc_valid <= 1'b1;
            lat_q     <= LAT_ONE;
          end else if (cfg_req) begin
            state_q   <= WR;
            cfg_ack   <= 1'b1;
            pid_d_wen <= (cfg_sel == CFG_SEL_D);
            pid_q_wen <= (cfg_sel == CFG_SEL_Q);
            pid_addr  <= cfg_addr;
            pid_data  <= cfg_data;
          end
        end
        WR: state_q <= IDLE;
        RUN: begin
          if (run_done) begin
            state_q      <= IDLE;
            last_latency <= sat_lat(lat_q);
          end else if (lat_q == LAT_LAST) begin
            state_q <= FAULT;
          end else begin
            lat_q <= lat_q + LAT_ONE;
          end
        end
        FAULT: if (!enable) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
